tdm_mux_8to1: RTL and testbench
===============================

# tdm_mux_8to1

Eight-channel time-division multiplexer: merges eight independent valid/ready input channels onto one registered output stream, tagging each word with its source channel number. It is the transmit-side counterpart of the 1-to-8 demultiplexer; `sel` from this block drives the demultiplexer's `sel` at the far end, so each word is steered back to the same channel index. Channel service is round-robin and fair, with a per-channel enable mask.

## Interface
Parameters:
- `DATA_W`, 8, width of each channel word and of `dout`

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `din`  input  8*DATA_W  channel words, channel i at bits [i*DATA_W +: DATA_W]
- `din_valid`  input  8  channel i has a word on its slice of `din`
- `din_ready`  output  8  one-hot or zero; channel i's word is consumed this cycle
- `chan_en`  input  8  channel i may be granted only when its bit is 1
- `dout`  output  DATA_W  registered output word
- `sel`  output  3  source channel index of `dout`
- `dout_valid`  output  1  `dout` and `sel` hold a word
- `dout_ready`  input  1  downstream accepts the word this cycle

## Operation
- Request vector: `req = din_valid & chan_en`.
- Load condition: `load = !dout_valid || dout_ready`.
- Round-robin pointer `ptr` (3 bits) marks the highest-priority channel. Grant = first set bit of `req` searching ptr, ptr+1, ... 7, 0, ... ptr-1 (modulo 8).
- When `load` and `req != 0`: `din_ready[grant] = 1` (all others 0); on the clock edge, `dout <= din[grant]`, `sel <= grant`, `dout_valid <= 1`, `ptr <= grant + 1` (7 wraps to 0).
- When `load` and `req == 0`: `din_ready = 0`; `dout_valid <= 0`; `dout`, `sel`, `ptr` hold.
- When `!load` (output stalled): `din_ready = 0`; all registers hold.
- `din_ready` is combinational from `req`, `ptr`, `dout_valid` and `dout_ready`. It never depends on `din` data.
- Clearing a `chan_en` bit removes that channel from arbitration in the same cycle. A word already in the output register is unaffected.
- Transfer rules: input transfer = `din_valid[i] && din_ready[i]`; output transfer = `dout_valid && dout_ready`. A word is never duplicated or dropped.

## Timing
- Reset values: `dout = 0`, `sel = 0`, `dout_valid = 0`, `ptr = 0`. `din_ready = 0` in every cycle where `rst = 1`.
- Reset mid-operation discards the word held in the output register. No input is consumed during a reset cycle.
- Latency is 1 cycle: a word accepted at edge N appears on `dout` after edge N.
- Full throughput: with `dout_ready` held at 1 and `req` non-zero, one word is moved per cycle.
- Output accept and new load can happen in the same cycle, giving back-to-back words with no bubble.
- Fairness: with all 8 channels continuously requesting, the grant order is 0,1,2,...,7,0,... Any requesting channel waits at most 7 grants.
- A single requesting channel is granted every cycle, because the pointer wrap places it back in the search.
- Stall: while `dout_valid && !dout_ready`, `dout` and `sel` stay stable.

## Structure
- Shared package `tdm_pkg` holds:
  - `NUM_CH = 8` and `SEL_W = 3`
  - typedef `ch_idx_t` (logic [SEL_W-1:0])
  - typedef `ch_mask_t` (logic [NUM_CH-1:0])
- Both this block and the receive-side demultiplexer wrapper import `tdm_pkg`.
- Sub-module `rr_arbiter8`:
  - inputs: `req`, `ptr`
  - outputs: one-hot `gnt` and index `gnt_idx`
  - purely combinational
- The top level holds the pointer, the output register and the handshake.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `din_valid` = 8'hFF → `dout_valid = 0`, `din_ready = 0`, `sel = 0`, `dout = 0`. The first grant after release is channel 0.
- **Round-robin:** all channels valid, `chan_en` = 8'hFF, `dout_ready = 1`, channel i data = 8'h10+i. Expect `sel` sequence 0..7,0 with `dout` 8'h10..8'h17,8'h10, one word per cycle.
- **Sparse requests and wrap:** only channels 2 and 6 valid, `ptr` = 0 → grants 2,6,2,6. Then only channel 6 valid → grants 6 every cycle.
- **Backpressure:** hold `dout_ready = 0` for 3 cycles after the first word (channel 0, 8'hA5). Expect `dout` = 8'hA5, `sel` = 0 stable and `din_ready` = 0 throughout. Release → channel 1 is granted in the release cycle, with no bubble.
- **Masking:** all channels valid, `chan_en` = 8'b1010_0000 → only channels 5 and 7 are granted, alternating. Clear bit 7 mid-stream → the next grant is 5.
- **Reset mid-stream:** assert `rst` while `dout_valid = 1` with a stalled word → next cycle `dout_valid = 0`, no input is consumed, and after release `ptr` restarts at 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the 8:1 transmit mux and the 1:8 receive demux.
// Combinational only; no latency.
// No flow control of its own; the types carry channel indices and masks.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0]  ch_idx_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  // Next channel index after idx. The 3-bit add wraps 7 back to 0.
  function automatic ch_idx_t ch_next(input ch_idx_t idx);
    return idx + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Round-robin 8-way arbiter: picks the first request at or after ptr (mod 8).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports:
//   req     - request vector, one bit per channel
//   ptr     - highest-priority channel this cycle
//   gnt     - one-hot grant, all zero when req is zero
//   gnt_idx - index of the granted channel (equals ptr when nothing is granted)
module rr_arbiter8
  import tdm_pkg::*;
(
  input  ch_mask_t req,
  input  ch_idx_t  ptr,
  output ch_mask_t gnt,
  output ch_idx_t  gnt_idx
);

  logic    found;
  ch_idx_t idx;

  // Walk the channels starting at ptr; the 3-bit index wraps on its own, so
  // the search order is ptr, ptr+1, ..., 7, 0, ..., ptr-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + ch_idx_t'(k);
      if (!found && req[idx]) begin
        found     = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_8to1.sv
// Eight-channel TDM mux: round-robin merges masked valid/ready inputs onto one tagged output.
// Latency: one cycle from input acceptance to dout/sel/dout_valid.
// Backpressure: output register reloads only when empty or being drained; otherwise din_ready is all zero.
//
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   din         - eight channel words, channel i at [i*DATA_W +: DATA_W]
//   din_valid   - per-channel word present
//   din_ready   - one-hot (or zero) consume strobe for the granted channel
//   chan_en     - per-channel arbitration enable
//   dout, sel   - registered output word and its source channel index
//   dout_valid  - dout/sel hold a word
//   dout_ready  - downstream accepts the word this cycle
module tdm_mux_8to1
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [NUM_CH-1:0]        din_valid,
  output logic [NUM_CH-1:0]        din_ready,
  input  logic [NUM_CH-1:0]        chan_en,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         sel,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  ch_mask_t req;
  logic     load;
  ch_mask_t gnt;
  ch_idx_t  gnt_idx;

  logic [DATA_W-1:0] dout_q, dout_d;
  ch_idx_t           sel_q, sel_d;
  logic              dout_valid_q, dout_valid_d;
  ch_idx_t           ptr_q, ptr_d;

  // Masked channels drop out of arbitration in the same cycle the mask clears.
  assign req  = din_valid & chan_en;
  // The output register can take a new word when empty or when its current
  // word leaves this cycle, which gives back-to-back words with no bubble.
  assign load = !dout_valid_q || dout_ready;

  rr_arbiter8 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    din_ready    = '0;
    dout_d       = dout_q;
    sel_d        = sel_q;
    dout_valid_d = dout_valid_q;
    ptr_d        = ptr_q;
    // Nothing is consumed during reset, so the strobe is gated by rst too.
    if (!rst && load) begin
      if (|req) begin
        din_ready    = gnt;
        dout_d       = din[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_d        = gnt_idx;
        dout_valid_d = 1'b1;
        // Moving the pointer past the winner is what makes service fair; a
        // lone requester is still found because the search wraps to it.
        ptr_d        = ch_next(gnt_idx);
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      sel_q        <= '0;
      dout_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      dout_q       <= dout_d;
      sel_q        <= sel_d;
      dout_valid_q <= dout_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign dout       = dout_q;
  assign sel        = sel_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
module tb_tdm_mux_8to1;

  logic        clk;
  logic        rst;
  logic [63:0] din;
  logic [7:0]  din_valid;
  logic [7:0]  din_ready;
  logic [7:0]  chan_en;
  logic [7:0]  dout;
  logic [2:0]  sel;
  logic        dout_valid;
  logic        dout_ready;

  tdm_mux_8to1 #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .chan_en    (chan_en),
    .dout       (dout),
    .sel        (sel),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         total;
  int         bad;
  logic [2:0] m_ptr;
  logic       m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference search: first set bit of r starting at p, modulo 8.
  function automatic logic [3:0] ref_gnt(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    res = 4'h0;
    for (int k = 7; k >= 0; k--) begin
      int j;
      j = (int'(p) + k) % 8;
      if (r[j]) res = {1'b1, 3'(j)};
    end
    return res;
  endfunction

  // One clock cycle. Inputs are already driven; checks happen at the falling
  // edge, then the reference state advances with the rising edge.
  task automatic cycle();
    logic [3:0] g;
    logic       ld;
    logic [7:0] exp_rdy;
    int         gi;
    exp_t       e;
    @(negedge clk);
    g       = ref_gnt(din_valid & chan_en, m_ptr);
    ld      = !m_vld || dout_ready;
    exp_rdy = (!rst && ld && g[3]) ? (8'h01 << g[2:0]) : 8'h00;
    chk("din_ready", {24'h0, din_ready}, {24'h0, exp_rdy});
    chk("dout_valid", {31'h0, dout_valid}, {31'h0, m_vld});
    if (m_vld) begin
      chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("sb_sel", {29'h0, sel}, {29'h0, e.s});
        chk("sb_dout", {24'h0, dout}, {24'h0, e.d});
        if (dout_ready && !rst) void'(sb.pop_front());
      end
    end
    if (rst) begin
      sb.delete();
      m_ptr = 3'd0;
      m_vld = 1'b0;
    end else if (ld) begin
      if (g[3]) begin
        gi  = int'(g[2:0]);
        e.s = g[2:0];
        e.d = din[gi*8 +: 8];
        sb.push_back(e);
        m_ptr = g[2:0] + 3'd1;
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_ptr = 3'd0;
    m_vld = 1'b0;
    rst        = 1'b1;
    din_valid  = 8'hFF;
    chan_en    = 8'hFF;
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'h10 + 8'(i);

    // Reset with every channel requesting.
    cycle();
    cycle();
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_sel", {29'h0, sel}, 32'h0);
    chk("rst_dout_valid", {31'h0, dout_valid}, 32'h0);

    // Round-robin over all channels, one word per cycle.
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("rr_sel", {29'h0, sel}, k % 8);
      chk("rr_dout", {24'h0, dout}, 32'h10 + (k % 8));
    end

    // Sparse requests on channels 2 and 6, then 6 alone.
    din_valid = 8'b0100_0100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("sparse_sel", {29'h0, sel}, (k % 2 == 0) ? 32'd2 : 32'd6);
    end
    din_valid = 8'b0100_0000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("single_sel", {29'h0, sel}, 32'd6);
    end

    // Drain, then channel 0 carries 8'hA5 and the output stalls.
    din_valid = 8'h00;
    cycle();
    chk("drain_valid", {31'h0, dout_valid}, 32'h0);
    din[7:0]  = 8'hA5;
    din_valid = 8'b0000_0011;
    cycle();
    chk("bp_first_sel", {29'h0, sel}, 32'd0);
    chk("bp_first_dout", {24'h0, dout}, 32'hA5);
    dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_dout", {24'h0, dout}, 32'hA5);
      chk("bp_hold_sel", {29'h0, sel}, 32'd0);
    end
    dout_ready = 1'b1;
    cycle();
    chk("bp_release_sel", {29'h0, sel}, 32'd1);
    chk("bp_release_dout", {24'h0, dout}, 32'h11);
    chk("bp_release_valid", {31'h0, dout_valid}, 32'h1);
    din[7:0]  = 8'h10;

    // Masking: only channels 5 and 7 may win; then 7 is masked off.
    din_valid = 8'hFF;
    chan_en   = 8'b1010_0000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("mask_sel", {29'h0, sel}, (k % 2 == 0) ? 32'd5 : 32'd7);
    end
    chan_en = 8'b0010_0000;
    cycle();
    chk("mask_clear_sel", {29'h0, sel}, 32'd5);

    // Reset while a word is stalled in the output register.
    dout_ready = 1'b0;
    cycle();
    chk("mid_stall_valid", {31'h0, dout_valid}, 32'h1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("mid_rst_sel", {29'h0, sel}, 32'h0);
    rst        = 1'b0;
    chan_en    = 8'hFF;
    dout_ready = 1'b1;
    cycle();
    chk("post_rst_sel", {29'h0, sel}, 32'd0);
    chk("post_rst_dout", {24'h0, dout}, 32'h10);
    cycle();
    chk("post_rst_sel2", {29'h0, sel}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
